// File: rtl/step_capture_if.sv
// step_capture_if: button/switch inputs, live datapath taps and captured display values.
// sw_live exists only when STEP_CAPTURE_LIVE_EN is defined.
interface step_capture_if #(
    parameter int W = 8
);
    logic         btn_step;
    logic         sw_run;
`ifdef STEP_CAPTURE_LIVE_EN
    logic         sw_live;
`endif
    logic [W-1:0] RdDataA_in;
    logic [W-1:0] RdDataB_in;
    logic [W-1:0] MuxD_in;
    logic [W-1:0] ALUOUT_in;
    logic         cpu_en;
    logic [W-1:0] RdDataA;
    logic [W-1:0] RdDataB;
    logic [W-1:0] MuxD;
    logic [W-1:0] ALUOUT;
    logic [7:0]   step_count;

    modport master (
`ifdef STEP_CAPTURE_LIVE_EN
        output sw_live,
`endif
        output btn_step, sw_run,
        output RdDataA_in, RdDataB_in, MuxD_in, ALUOUT_in,
        input  cpu_en, RdDataA, RdDataB, MuxD, ALUOUT, step_count
    );

    modport slave (
`ifdef STEP_CAPTURE_LIVE_EN
        input  sw_live,
`endif
        input  btn_step, sw_run,
        input  RdDataA_in, RdDataB_in, MuxD_in, ALUOUT_in,
        output cpu_en, RdDataA, RdDataB, MuxD, ALUOUT, step_count
    );
endinterface

// File: rtl/step_capture.sv
// step_capture: debounced single-step / periodic run strobe with datapath snapshot.
// Define STEP_CAPTURE_LIVE_EN to add sw_live (outputs follow inputs every cycle).
module step_capture #(
    parameter int DB_COUNT = 1_000_000,
    parameter int RUN_DIV  = 50_000_000,
    parameter int W        = 8
) (
    input logic          clk,
    input logic          reset,
    step_capture_if.slave bus
);
    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam int RDW = $clog2(RUN_DIV + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HIGH,
        PRESSED,
        WAIT_LOW
    } db_state_t;

    logic [1:0]   btn_sync;
    logic [1:0]   run_sync;
    logic         btn_s;
    logic         run_s;

    db_state_t    state;
    logic [DBW-1:0] db_cnt;
    logic         db_top;
    logic         press_p;

    logic [RDW-1:0] run_cnt;
    logic         run_tick;

    logic         cpu_en_q;
    logic         cap_pend;
    logic         load;
    logic [7:0]   step_cnt_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] d_q;
    logic [W-1:0] o_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync <= '0;
            run_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[0], bus.btn_step};
            run_sync <= {run_sync[0], bus.sw_run};
        end
    end

    assign btn_s = btn_sync[1];
    assign run_s = run_sync[1];

    assign db_top  = (db_cnt == DBW'(DB_COUNT - 1));
    assign press_p = (state == WAIT_HIGH) && btn_s && db_top;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= WAIT_HIGH;
                        db_cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_s)
                        state <= IDLE;
                    else if (db_top)
                        state <= PRESSED;
                    else
                        db_cnt <= db_cnt + 1'b1;
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state  <= WAIT_LOW;
                        db_cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (btn_s)
                        state <= PRESSED;
                    else if (db_top)
                        state <= IDLE;
                    else
                        db_cnt <= db_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Divider parks at zero in step mode so run mode always starts a full period.
    assign run_tick = run_s && (run_cnt == RDW'(RUN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run_cnt <= '0;
        else if (!run_s || run_tick)
            run_cnt <= '0;
        else
            run_cnt <= run_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_en_q   <= 1'b0;
            cap_pend   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            cpu_en_q <= run_s ? run_tick : press_p;
            cap_pend <= cpu_en_q;
            if (cpu_en_q)
                step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

`ifdef STEP_CAPTURE_LIVE_EN
    logic [1:0] live_sync;
    logic       live_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            live_sync <= '0;
        else
            live_sync <= {live_sync[0], bus.sw_live};
    end

    assign live_s = live_sync[1];
    assign load   = cap_pend | live_s;
`else
    assign load   = cap_pend;
`endif

    // Snapshot one cycle after the strobe, once the CPU has settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            d_q <= '0;
            o_q <= '0;
        end else if (load) begin
            a_q <= bus.RdDataA_in;
            b_q <= bus.RdDataB_in;
            d_q <= bus.MuxD_in;
            o_q <= bus.ALUOUT_in;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.step_count = step_cnt_q;
    assign bus.RdDataA    = a_q;
    assign bus.RdDataB    = b_q;
    assign bus.MuxD       = d_q;
    assign bus.ALUOUT     = o_q;
endmodule

// File: tb/tb_step_capture.sv
// tb_step_capture: random and directed stimulus against a run-length model.
// Model: a level flips after DB_COUNT+1 equal synchronised samples; run ticks every RUN_DIV.
module tb_step_capture;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   obs = 0;
    bit   fixed = 1'b0;

    step_capture_if #(.W(W)) bus ();

    step_capture #(
        .DB_COUNT(DB),
        .RUN_DIV (RD),
        .W       (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0]   m_bh, m_rh, m_lh;
    logic         m_lvl, m_en, m_cap;
    int           m_dif, m_rlen;
    logic [7:0]   m_cnt;
    logic [W-1:0] m_a, m_b, m_d, m_o;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_bh = '0; m_rh = '0; m_lh = '0;
        m_lvl = 0; m_en = 0; m_cap = 0;
        m_dif = 0; m_rlen = 0; m_cnt = '0;
        m_a = '0; m_b = '0; m_d = '0; m_o = '0;
    endtask

    task automatic m_step();
        logic bs, rs, press, tick, nen, ld;
        bs = m_bh[1];
        rs = m_rh[1];
        press = 1'b0;
        if (bs != m_lvl) begin
            m_dif++;
            if (m_dif == DB + 1) begin
                m_lvl = bs;
                m_dif = 0;
                press = bs;
            end
        end else begin
            m_dif = 0;
        end
        tick = 1'b0;
        if (rs) begin
            m_rlen++;
            tick = (m_rlen % RD) == 0;
        end else begin
            m_rlen = 0;
        end
        nen = rs ? tick : press;
        ld = m_cap;
`ifdef STEP_CAPTURE_LIVE_EN
        ld = ld | m_lh[1];
        m_lh = {m_lh[0], bus.sw_live};
`endif
        if (ld) begin
            m_a = bus.RdDataA_in;
            m_b = bus.RdDataB_in;
            m_d = bus.MuxD_in;
            m_o = bus.ALUOUT_in;
        end
        m_cnt = m_cnt + 8'(m_en);
        m_cap = m_en;
        m_en  = nen;
        m_bh = {m_bh[0], bus.btn_step};
        m_rh = {m_rh[0], bus.sw_run};
    endtask

    task automatic cyc(input logic b, input logic r);
        bus.btn_step = b;
        bus.sw_run   = r;
        if (!fixed) begin
            bus.RdDataA_in = 8'($urandom);
            bus.RdDataB_in = 8'($urandom);
            bus.MuxD_in    = 8'($urandom);
            bus.ALUOUT_in  = 8'($urandom);
        end
        m_step();
        @(posedge clk);
        @(negedge clk);
        chk("cpu_en", 32'(bus.cpu_en), 32'(m_en));
        chk("step_count", 32'(bus.step_count), 32'(m_cnt));
        chk("RdDataA", 32'(bus.RdDataA), 32'(m_a));
        chk("RdDataB", 32'(bus.RdDataB), 32'(m_b));
        chk("MuxD", 32'(bus.MuxD), 32'(m_d));
        chk("ALUOUT", 32'(bus.ALUOUT), 32'(m_o));
        if (bus.cpu_en) obs++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        chk("rst_cpu_en", 32'(bus.cpu_en), 0);
        chk("rst_count", 32'(bus.step_count), 0);
        chk("rst_outs", {bus.RdDataA, bus.RdDataB, bus.MuxD, bus.ALUOUT}, 0);
        m_reset();
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        bit seen;
        logic [7:0] last;
        reset = 1'b0;
        bus.btn_step = 0;
        bus.sw_run = 0;
`ifdef STEP_CAPTURE_LIVE_EN
        bus.sw_live = 0;
`endif
        bus.RdDataA_in = 8'hAA;
        bus.RdDataB_in = 8'hAA;
        bus.MuxD_in    = 8'hAA;
        bus.ALUOUT_in  = 8'hAA;
        repeat (3) @(negedge clk);
        chk("init_cpu_en", 32'(bus.cpu_en), 0);
        chk("init_count", 32'(bus.step_count), 0);
        chk("init_outs", {bus.RdDataA, bus.RdDataB, bus.MuxD, bus.ALUOUT}, 0);
        m_reset();
        reset = 1'b1;

        // Clean press with fixed datapath values
        fixed = 1'b1;
        bus.RdDataA_in = 8'h12;
        bus.RdDataB_in = 8'h34;
        bus.MuxD_in    = 8'h56;
        bus.ALUOUT_in  = 8'h78;
        obs = 0;
        n = 0;
        while (n < 20) begin
            cyc(1, 0);
            n++;
            if (bus.cpu_en && n < 18) begin
                cyc(1, 0);
                n++;
                chk("lat_n1", 32'(bus.ALUOUT), 0);
                cyc(1, 0);
                n++;
                chk("lat_n2", {bus.RdDataA, bus.RdDataB, bus.MuxD, bus.ALUOUT},
                    32'h12345678);
            end
        end
        repeat (10) cyc(0, 0);
        chk("press_pulses", obs, 1);
        chk("press_count", 32'(bus.step_count), 1);
        fixed = 1'b0;

        // Bounce, then a long hold with a short release glitch
        obs = 0;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 3)) cyc(1, 0);
            repeat ($urandom_range(1, 3)) cyc(0, 0);
        end
        repeat (10) cyc(1, 0);
        repeat (2) cyc(0, 0);
        repeat (8) cyc(1, 0);
        repeat (10) cyc(0, 0);
        chk("bounce_pulses", obs, 1);

        // Run mode with a button press inside the window
        obs = 0;
        for (int i = 0; i < 40; i++) cyc(logic'(i >= 5 && i < 15), 1);
        chk("run_pulses", obs, 4);
        repeat (10) cyc(0, 0);

        // Step counter wrap
        do_reset(3);
        obs = 0;
        guard = 0;
        while (obs < 256 && guard < 256 * RD + 50) begin
            cyc(0, 1);
            guard++;
        end
        chk("wrap_pulses", obs, 256);
        chk("wrap_255", 32'(bus.step_count), 255);
        cyc(0, 0);
        chk("wrap_0", 32'(bus.step_count), 0);
        repeat (4) cyc(0, 0);

        // Reset while debouncing
        repeat (4) cyc(1, 0);
        do_reset(3);
        obs = 0;
        repeat (3) cyc(1, 0);
        chk("rst_db_nopulse", obs, 0);
        repeat (10) cyc(1, 0);
        repeat (10) cyc(0, 0);

        // Reset between strobe and capture
        fixed = 1'b1;
        bus.RdDataA_in = 8'hAA;
        bus.RdDataB_in = 8'hAA;
        bus.MuxD_in    = 8'hAA;
        bus.ALUOUT_in  = 8'hAA;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1, 0);
            seen = bus.cpu_en;
        end
        chk("rst_cap_en_seen", 32'(seen), 1);
        bus.btn_step = 0;
        do_reset(2);
        repeat (4) cyc(0, 0);
        chk("rst_cap_hold", {bus.RdDataA, bus.RdDataB, bus.MuxD, bus.ALUOUT}, 0);
        chk("rst_cap_count", 32'(bus.step_count), 0);
        fixed = 1'b0;

`ifdef STEP_CAPTURE_LIVE_EN
        bus.sw_live = 1;
        repeat (3) cyc(0, 0);
        for (int i = 0; i < 8; i++) begin
            last = 8'($urandom);
            fixed = 1'b1;
            bus.ALUOUT_in = last;
            cyc(0, 0);
            fixed = 1'b0;
            chk("live_alu", 32'(bus.ALUOUT), 32'(last));
        end
        bus.sw_live = 0;
`endif

        // Random mixed stimulus
        for (int s = 0; s < 100; s++) begin
            logic rb, rr;
            rb = 1'($urandom);
            rr = ($urandom_range(0, 3) == 0);
`ifdef STEP_CAPTURE_LIVE_EN
            bus.sw_live = ($urandom_range(0, 5) == 0);
`endif
            repeat ($urandom_range(1, 12)) cyc(rb, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_capture.md
Name: step_capture

Overview:
- Front-end for single-step CPU demos.
- Debounces the step button and generates a one-cycle CPU enable. In run mode it generates a periodic enable instead.
- Snapshots the CPU datapath values (RdDataA, RdDataB, MuxD, ALUOUT) after each enable, so the downstream seven-segment scanner shows stable values.
- Sits between the CPU datapath and the display scanner.

Parameters:
- DB_COUNT, 1_000_000: consecutive stable samples needed to accept a button level change (10 ms at 100 MHz).
- RUN_DIV, 50_000_000: clock cycles between cpu_en pulses in run mode.
- W, 8: datapath width of each captured value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_step  in  1  raw, asynchronous step pushbutton.
- sw_run  in  1  raw, asynchronous mode switch: 1 = run, 0 = step.
- RdDataA_in  in  W  live register-file port A.
- RdDataB_in  in  W  live register-file port B.
- MuxD_in  in  W  live write-back mux output.
- ALUOUT_in  in  W  live ALU result.
- cpu_en  out  1  one-cycle CPU advance strobe.
- RdDataA  out  W  captured port A, to the display.
- RdDataB  out  W  captured port B, to the display.
- MuxD  out  W  captured mux value, to the display.
- ALUOUT  out  W  captured ALU value, to the display.
- step_count  out  8  number of cpu_en pulses issued, modulo 256.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - Debounce FSM is in IDLE; debounce counter, run divider, capture flag and synchronisers are cleared.
  - The CPU is not advanced while reset is low.
- Synchronisation: btn_step and sw_run each pass through a 2-FF synchroniser. All logic below uses the synchronised values (btn_s, run_s).
- Debounce FSM, states IDLE, WAIT_HIGH, PRESSED, WAIT_LOW:
  - IDLE: btn_s=1 → WAIT_HIGH, counter cleared.
  - WAIT_HIGH: counter increments while btn_s=1. btn_s=0 → IDLE. Counter reaching DB_COUNT-1 with btn_s=1 → PRESSED, and press_p=1 for exactly that transition cycle.
  - PRESSED: btn_s=0 → WAIT_LOW, counter cleared.
  - WAIT_LOW: counter increments while btn_s=0. btn_s=1 → PRESSED. Counter reaching DB_COUNT-1 → IDLE.
  - Holding the button produces exactly one press_p. A release glitch shorter than DB_COUNT produces none.
- Run divider:
  - Counts 0..RUN_DIV-1 while run_s=1. run_tick=1 on terminal count, then wraps to 0.
  - Held at 0 while run_s=0, so the first tick after entering run mode comes RUN_DIV cycles later.
- cpu_en:
  - Step mode (run_s=0): cpu_en is a register equal to press_p.
  - Run mode (run_s=1): cpu_en is a register equal to run_tick. press_p is ignored, though the FSM keeps tracking the button.
  - At most one cpu_en per cycle, even if press_p and run_tick coincide.
- Capture timing:
  - cpu_en high in cycle N; the CPU updates at the end of N.
  - The capture flag is set at the end of N.
  - All four *_in values are registered into the outputs at the end of N+1, so they are valid from N+2 onward.
  - Outputs hold between captures.
- step_count: increments at the end of each cpu_en cycle and wraps 255→0.
- Mode change during a pending capture: the capture still completes.
- Reset asserted mid-debounce or mid-capture: everything is cleared immediately. No cpu_en is issued after reset releases until a fresh debounce completes or RUN_DIV elapses.

Optional Feature:
- Macro: STEP_CAPTURE_LIVE_EN.
- Defined:
  - Adds input sw_live (1 bit, raw, 2-FF synchronised).
  - While sw_live_s=1, the four outputs register *_in every cycle (1-cycle latency), overriding snapshot hold.
  - When sw_live_s returns to 0, outputs hold their last value until the next capture.
- Not defined: the port is absent and outputs update only on captures.

Test Plan:
- Reset: DB_COUNT=4, RUN_DIV=8; drive reset=0 with all *_in=8'hAA → all outputs 0, cpu_en=0, step_count=0.
- Clean press, step mode: btn_step high for 20 cycles → exactly one cpu_en pulse 1 cycle after press_p.
  - With RdDataA_in=8'h12, RdDataB_in=8'h34, MuxD_in=8'h56, ALUOUT_in=8'h78: these values appear on the outputs 2 cycles after cpu_en.
  - step_count=1.
- Bounce: btn_step toggles with high times of 1–3 cycles, then stays high for 10 cycles → exactly one cpu_en. A 2-cycle release glitch while held → no extra cpu_en.
- Run mode: sw_run=1 for 40 cycles → cpu_en every 8 cycles (4 pulses after the sync/divider offset); button presses during this window add none.
- Wrap: issue 256 steps → step_count goes 255→0.
- Mid-operation reset: assert reset in WAIT_HIGH and also between cpu_en and capture → no cpu_en, outputs 0.
- Live mode (with STEP_CAPTURE_LIVE_EN): sw_live=1 → ALUOUT tracks ALUOUT_in with 1-cycle lag.
